mem_port_arbiter: RTL and testbench

- Sequences one shared single-port memory between the instruction-fetch port (I) and the load/store port (D) of the RV32I core.
- Serves lw/lh/lb/sw/sh/sb and fetch traffic one transaction at a time.
- Drives a core-wide stall while any request is outstanding.
- Sits between the core datapath/control unit and the memory model.

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the RV32I fetch (I) and load/store (D) ports.
// One transaction is in flight at a time; D has priority unless a D burst has starved I.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MAX_WAIT    = 255,
    parameter int unsigned D_BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                stall,
    output logic                timeout_err
);
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int unsigned BURST_W = $clog2(D_BURST_MAX + 1);

    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [BURST_W-1:0] BURST_TOP = BURST_W'(D_BURST_MAX);
    localparam logic [DATA_W-1:0]  NOP_WORD  = DATA_W'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e              state_q, state_d;
    logic                dsel_q, dsel_d;
    logic                m_req_q, m_req_d;
    logic                m_we_q, m_we_d;
    logic [BE_W-1:0]     m_be_q, m_be_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_q, timeout_d;
    logic                forced_i;
    logic                complete;

    assign forced_i = i_req && (burst_q == BURST_TOP);

    always_comb begin
        state_d   = state_q;
        dsel_d    = dsel_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        burst_d   = i_req ? burst_q : '0;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        complete  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req && !forced_i) begin
                    dsel_d    = 1'b1;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_be_d    = d_be;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    wait_d    = '0;
                    state_d   = ISSUE;
                    if (i_req && burst_q != BURST_TOP) begin
                        burst_d = burst_q + BURST_W'(1);
                    end
                end else if (i_req) begin
                    dsel_d    = 1'b0;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_be_d    = '1;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    wait_d    = '0;
                    burst_d   = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                wait_d = wait_q + WAIT_W'(1);
                if (state_q == ISSUE) begin
                    if (m_ready) begin
                        m_req_d  = 1'b0;
                        state_d  = WAIT;
                        complete = m_rvalid;
                    end
                end else begin
                    complete = m_rvalid;
                end
                // A real completion on the last allowed cycle wins over the timeout.
                if (complete) begin
                    state_d = DONE;
                    if (!m_we_q) begin
                        if (dsel_q) d_rdata_d = m_rdata;
                        else        i_rdata_d = m_rdata;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = DONE;
                    m_req_d   = 1'b0;
                    timeout_d = 1'b1;
                    if (dsel_q) d_rdata_d = '0;
                    else        i_rdata_d = NOP_WORD;
                end
                if (state_d == DONE) begin
                    i_ack_d = !dsel_q;
                    d_ack_d = dsel_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dsel_q    <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            burst_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dsel_q    <= dsel_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            burst_q   <= burst_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign m_req       = m_req_q;
    assign m_we        = m_we_q;
    assign m_be        = m_be_q;
    assign m_addr      = m_addr_q;
    assign m_wdata     = m_wdata_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign i_ack       = i_ack_q;
    assign d_ack       = d_ack_q;
    assign timeout_err = timeout_q;
    assign stall       = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random I/D traffic scored against a
// transaction-level arbitration and memory model.
module tb_mem_port_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned MAXW = 8;
    localparam int          DBM  = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_ack, d_req, d_we, d_ack;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, m_be;
    logic        m_req, m_we, m_ready, m_rvalid, stall, timeout_err;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW), .D_BURST_MAX(DBM)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .stall(stall), .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Memory responder controls (written by the main process only)
    int cfg_rdy = -1;
    int cfg_rv  = -1;
    bit no_rv   = 1'b0;
    int inj_req = 0;

    // Responder acceptance log (written by the responder only)
    txn_t acc_log [0:255];
    int   acc_wr = 0;
    int   acc_rd = 0;

    // Reference model state
    logic [31:0] ref_mem [0:255];
    logic [31:0] hold_d = '0;
    txn_t        iq [0:15];
    txn_t        dq [0:15];

    function automatic logic [31:0] init_word(input int k);
        if (k == 64) return 32'h0050_0093;
        return (32'(k) * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    function automatic txn_t rand_txn(input bit is_d);
        txn_t       t;
        logic [7:0] w;
        w       = 8'($urandom);
        t.addr  = {22'd0, w, 2'b00};
        t.we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
        t.be    = is_d ? 4'($urandom_range(1, 15)) : 4'hF;
        t.wdata = is_d ? $urandom : 32'd0;
        return t;
    endfunction

    task automatic ref_write(input txn_t t);
        for (int b = 0; b < 4; b++)
            if (t.be[b]) ref_mem[t.addr[9:2]][8*b +: 8] = t.wdata[8*b +: 8];
    endtask

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input int ip, input int dp, input int ni, input int nd);
        i_req  = (ip < ni);
        i_addr = (ip < ni) ? iq[ip].addr : 32'd0;
        d_req  = (dp < nd);
        if (dp < nd) begin
            d_we = dq[dp].we; d_be = dq[dp].be; d_addr = dq[dp].addr; d_wdata = dq[dp].wdata;
        end
    endtask

    // Memory environment: random acceptance and completion delays
    initial begin
        logic [31:0] mem [0:255];
        logic [31:0] rdat;
        int          rd, rv, inj_done;
        inj_done = 0;
        for (int k = 0; k < 256; k++) mem[k] = init_word(k);
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        forever begin
            tick();
            if (inj_req != inj_done) begin
                inj_done++;
                m_rvalid = 1'b1; m_rdata = 32'hDEAD_BEEF;
                tick();
                m_rvalid = 1'b0;
            end else if (m_req) begin
                rd = (cfg_rdy < 0) ? int'($urandom_range(0, 3)) : cfg_rdy;
                rv = (cfg_rv < 0) ? int'($urandom_range(0, 2)) : cfg_rv;
                repeat (rd) tick();
                acc_log[acc_wr[7:0]] = {m_addr, m_we, m_be, m_wdata};
                acc_wr++;
                if (m_we) begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[b]) mem[m_addr[9:2]][8*b +: 8] = m_wdata[8*b +: 8];
                    rdat = $urandom;
                end else begin
                    rdat = mem[m_addr[9:2]];
                end
                m_ready = 1'b1;
                if (!no_rv && rv == 0) begin m_rvalid = 1'b1; m_rdata = rdat; end
                tick();
                m_ready = 1'b0; m_rvalid = 1'b0;
                if (!no_rv && rv > 0) begin
                    repeat (rv - 1) tick();
                    m_rvalid = 1'b1; m_rdata = rdat;
                    tick();
                    m_rvalid = 1'b0;
                end
            end
        end
    end

    // Runs queued I and D transactions with both requesters issuing back-to-back.
    task automatic run(input int ni, input int nd, output logic [15:0] ord);
        bit          ek [$];
        txn_t        et [$];
        logic [31:0] er [$];
        txn_t        t, lg;
        int ii = 0, di = 0, burst = 0, ip = 0, dp = 0, g = 0, cyc = 0;
        ord = '0;
        while (ii < ni || di < nd) begin
            if (di < nd && !(ii < ni && burst == DBM)) begin
                t = dq[di]; di++;
                if (t.we) ref_write(t);
                else      hold_d = ref_mem[t.addr[9:2]];
                ek.push_back(1'b1); et.push_back(t); er.push_back(hold_d);
                burst = (ii < ni) ? ((burst < DBM) ? burst + 1 : burst) : 0;
            end else begin
                t = iq[ii]; ii++;
                ek.push_back(1'b0); et.push_back(t); er.push_back(ref_mem[t.addr[9:2]]);
                burst = 0;
            end
        end
        tick();
        drive(ip, dp, ni, nd);
        while (g < ni + nd && cyc < 400) begin
            sample();
            cyc++;
            if (i_ack === 1'b1 || d_ack === 1'b1) begin
                chk("run_single_ack", 96'(i_ack & d_ack), 96'(0));
                chk("run_grant_kind", 96'(d_ack), 96'(ek[g]));
                chk("run_accepted", 96'(acc_rd < acc_wr), 96'(1));
                lg = acc_log[acc_rd[7:0]];
                if (ek[g]) begin
                    chk("run_d_txn", 96'(lg), 96'(et[g]));
                    chk("run_d_rdata", 96'(d_rdata), 96'(er[g]));
                end else begin
                    chk("run_i_txn", 96'({lg.addr, lg.we, lg.be}), 96'({et[g].addr, 1'b0, 4'hF}));
                    chk("run_i_rdata", 96'(i_rdata), 96'(er[g]));
                end
                if (g < 16) ord[g] = d_ack;
                if (d_ack === 1'b1) dp++; else ip++;
                acc_rd++;
                g++;
            end
            tick();
            drive(ip, dp, ni, nd);
        end
        chk("run_complete", 96'(g), 96'(ni + nd));
        i_req = 1'b0; d_req = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] ord;
        txn_t        lg;
        int          acks, ack_k, ni, nd;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
        repeat (3) tick();

        // Reset state
        sample();
        chk("rst_m_bus", 96'({m_req, m_we, m_be, m_addr, m_wdata}), 96'(0));
        chk("rst_acks", 96'({i_ack, d_ack}), 96'(0));
        chk("rst_rdata", 96'({i_rdata, d_rdata}), 96'(0));
        chk("rst_flags", 96'({timeout_err, stall}), 96'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Single fetch at minimum latency
        cfg_rdy = 0; cfg_rv = 1;
        i_req = 1'b1; i_addr = 32'h100;
        sample();
        chk("t1_stall_c0", 96'(stall), 96'(1));
        chk("t1_noack_c0", 96'(i_ack), 96'(0));
        sample();
        chk("t1_mreq_c1", 96'(m_req), 96'(1));
        chk("t1_mbus_c1", 96'({m_addr, m_we, m_be}), 96'({32'h100, 1'b0, 4'hF}));
        chk("t1_stall_c1", 96'(stall), 96'(1));
        sample();
        chk("t1_mreq_c2", 96'(m_req), 96'(0));
        chk("t1_noack_c2", 96'({i_ack, stall}), 96'({1'b0, 1'b1}));
        sample();
        chk("t1_ack_c3", 96'({i_ack, d_ack}), 96'({1'b1, 1'b0}));
        chk("t1_rdata", 96'(i_rdata), 96'(32'h0050_0093));
        chk("t1_stall_c3", 96'(stall), 96'(0));
        tick();
        i_req = 1'b0;
        sample();
        chk("t1_ack_pulse", 96'(i_ack), 96'(0));
        acc_rd++;
        tick();

        // Store contending with a fetch
        cfg_rdy = -1; cfg_rv = -1;
        dq[0] = '{addr: 32'h200, we: 1'b1, be: 4'b0011, wdata: 32'h0000_BEEF};
        iq[0] = '{addr: 32'h104, we: 1'b0, be: 4'hF, wdata: 32'h0};
        run(1, 1, ord);
        chk("t2_order", 96'(ord[1:0]), 96'(2'b01));

        // Starvation guard with I pending throughout
        for (int k = 0; k < 6; k++) dq[k] = rand_txn(1'b1);
        for (int k = 0; k < 2; k++) iq[k] = rand_txn(1'b0);
        run(2, 6, ord);
        chk("t3_order", 96'(ord[5:0]), 96'(6'b101111));

        // Backpressure: five cycles of m_ready low
        cfg_rdy = 5; cfg_rv = 1;
        dq[0] = '{addr: 32'h300, we: 1'b1, be: 4'b1100, wdata: 32'hCAFE_F00D};
        ref_write(dq[0]);
        drive(0, 0, 0, 1);
        sample();
        for (int k = 0; k < 6; k++) begin
            sample();
            chk("t4_mreq_held", 96'(m_req), 96'(1));
            chk("t4_mbus_stable", 96'({m_addr, m_we, m_be, m_wdata}), 96'(dq[0]));
            chk("t4_no_early_ack", 96'(d_ack), 96'(0));
        end
        acks = 0; ack_k = -1;
        for (int k = 0; k < 8; k++) begin
            sample();
            if (d_ack === 1'b1) begin
                acks++; ack_k = k;
                chk("t4_rdata_kept", 96'(d_rdata), 96'(hold_d));
            end
            tick();
            if (acks > 0) d_req = 1'b0;
        end
        chk("t4_ack_count", 96'(acks), 96'(1));
        chk("t4_ack_cycle", 96'(ack_k), 96'(1));
        lg = acc_log[acc_rd[7:0]];
        chk("t4_accepted", 96'(lg), 96'(dq[0]));
        acc_rd++;

        // Timeout on a load that never completes
        cfg_rdy = 0; no_rv = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h40;
        sample();
        for (int k = 0; k < 8; k++) begin
            sample();
            chk("t5_no_early_ack", 96'(d_ack), 96'(0));
        end
        chk("t5_err_before", 96'(timeout_err), 96'(0));
        sample();
        chk("t5_ack", 96'(d_ack), 96'(1));
        chk("t5_rdata_zero", 96'(d_rdata), 96'(0));
        chk("t5_err_set", 96'(timeout_err), 96'(1));
        tick();
        d_req = 1'b0;
        hold_d = '0;
        acc_rd++;
        repeat (4) tick();
        sample();
        chk("t5_err_sticky", 96'({timeout_err, d_ack}), 96'({1'b1, 1'b0}));

        // Reset while waiting, then a stale m_rvalid
        tick();
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80;
        repeat (3) tick();
        rst_n = 1'b0; d_req = 1'b0;
        sample();
        inj_req++;
        tick();
        rst_n = 1'b1;
        acc_rd++;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("t6_no_ack", 96'({i_ack, d_ack}), 96'(0));
            chk("t6_m_bus", 96'({m_req, m_we, m_be, m_addr, m_wdata}), 96'(0));
            chk("t6_rdata", 96'({i_rdata, d_rdata}), 96'(0));
            chk("t6_flags", 96'({timeout_err, stall}), 96'(0));
            tick();
        end
        no_rv = 1'b0;
        hold_d = '0;

        // Random mixed traffic
        cfg_rdy = -1; cfg_rv = -1;
        for (int r = 0; r < 10; r++) begin
            ni = int'($urandom_range(0, 5));
            nd = int'($urandom_range(1, 7));
            for (int k = 0; k < ni; k++) iq[k] = rand_txn(1'b0);
            for (int k = 0; k < nd; k++) dq[k] = rand_txn(1'b1);
            run(ni, nd, ord);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
